sseg_reader: RTL and testbench

Receive-side counterpart of the team's hex-to-seven-segment decoder. It watches a multiplexed, active-low seven-segment display bus (segment lines plus digit anodes), waits until each digit's pattern is stable, and decodes it back to a 4-bit value. It keeps a per-digit error flag and pulses a frame-valid strobe once every digit has been captured. It sits on the board-test and loopback path, so the value driven to the display can be checked in-system.

---
 rtl/sseg_pkg.sv | 38 +++
 rtl/sseg_pattern_decode.sv | 34 +++
 rtl/sseg_reader.sv | 169 ++++++++++++++++
 tb/tb_sseg_reader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment loopback reader.
// Holds the active-low segment patterns (bit 6 = g ... bit 0 = a), the
// value reported for the "H" out-of-range glyph, the reader state type
// and a saturating increment for the stability counter.
package sseg_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned CNT_W = 8;

    // Active-low glyphs; the display driver uses the same constants
    localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_H = 7'b0001001;

    // Nibble reported when the driver shows "H" (value out of range)
    localparam logic [NIB_W-1:0] NIBBLE_H = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HELD  = 2'd2
    } state_e;

    // Stability counter increment that sticks at all-ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sseg_pattern_decode.sv
// Combinational seven-segment pattern decoder.
// Ports:
//   i_pattern  - active-low segment pattern, bit 6 = g ... bit 0 = a
//   o_nibble_c - decoded value (0..9, 4'hF for "H", 0 when unrecognised)
//   o_err_c    - high when the pattern is not a known glyph
module sseg_pattern_decode
    import sseg_pkg::*;
(
    input  logic [SEG_W-1:0] i_pattern,
    output logic [NIB_W-1:0] o_nibble_c,
    output logic             o_err_c
);

    // Table lookup; anything not listed is flagged and reads as zero
    always_comb begin
        o_nibble_c = '0;
        o_err_c    = 1'b0;
        case (i_pattern)
            SEG_0:   o_nibble_c = 4'h0;
            SEG_1:   o_nibble_c = 4'h1;
            SEG_2:   o_nibble_c = 4'h2;
            SEG_3:   o_nibble_c = 4'h3;
            SEG_4:   o_nibble_c = 4'h4;
            SEG_5:   o_nibble_c = 4'h5;
            SEG_6:   o_nibble_c = 4'h6;
            SEG_7:   o_nibble_c = 4'h7;
            SEG_8:   o_nibble_c = 4'h8;
            SEG_9:   o_nibble_c = 4'h9;
            SEG_H:   o_nibble_c = NIBBLE_H;
            default: o_err_c    = 1'b1;
        endcase
    end

endmodule

// File: rtl/sseg_reader.sv
// Receive-side reader for a multiplexed, active-low seven-segment bus.
// Each digit dwell is captured once its sample (anode + segments) has been
// identical for STABLE_CYCLES consecutive registered samples; a frame strobe
// fires when every digit has been captured since the previous strobe.
// Ports:
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_sseg         - segment lines, active-low, bit 6 = g ... bit 0 = a
//   i_an           - digit anodes, active-low, one low = valid dwell
//   o_digits       - decoded nibbles, digit k in [4k+3:4k]
//   o_err          - per-digit flag: last capture was not a known glyph
//   o_valid        - one-cycle frame-complete pulse
module sseg_reader
    import sseg_pkg::*;
#(
    parameter int unsigned N_DIGITS      = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [SEG_W-1:0]          i_sseg,
    input  logic [N_DIGITS-1:0]       i_an,
    output logic [NIB_W*N_DIGITS-1:0] o_digits,
    output logic [N_DIGITS-1:0]       o_err,
    output logic                      o_valid
);

    localparam int unsigned DIG_W = NIB_W * N_DIGITS;

    // A fresh sample already satisfies the stability window when it is 1
    localparam logic RESTART_HIT = (STABLE_CYCLES <= 1);

    // Input register stage and the sample seen one cycle earlier
    logic [SEG_W-1:0]    sseg_q, prev_sseg_q;
    logic [N_DIGITS-1:0] an_q,   prev_an_q;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [N_DIGITS-1:0] seen_q,   seen_d;
    logic [DIG_W-1:0]    digits_q, digits_d;
    logic [N_DIGITS-1:0] err_q,    err_d;
    logic                valid_q,  valid_d;

    logic [N_DIGITS-1:0] low_c;
    logic                one_hot_c;
    logic                same_c;
    logic                capture_c;
    logic [N_DIGITS-1:0] seen_set_c;
    logic [NIB_W-1:0]    dec_nib_c;
    logic                dec_err_c;

    // Decode the registered pattern; only consulted on a capture edge
    sseg_pattern_decode u_decode (
        .i_pattern  (sseg_q),
        .o_nibble_c (dec_nib_c),
        .o_err_c    (dec_err_c)
    );

    // Exactly one anode low: non-zero and a single set bit after inversion
    always_comb begin
        low_c     = ~an_q;
        one_hot_c = (low_c != '0) &&
                    ((low_c & (low_c - N_DIGITS'(1))) == '0);
        same_c    = (an_q == prev_an_q) && (sseg_q == prev_sseg_q);
    end

    // Input sampling; reset value is a blank display with no anode active
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sseg_q      <= '1;
            an_q        <= '1;
            prev_sseg_q <= '1;
            prev_an_q   <= '1;
        end else begin
            sseg_q      <= i_sseg;
            an_q        <= i_an;
            prev_sseg_q <= sseg_q;
            prev_an_q   <= an_q;
        end
    end

    // State, counter and capture registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            seen_q   <= '0;
            digits_q <= '0;
            err_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
            digits_q <= digits_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
        end
    end

    // Next-state, stability tracking and capture/frame bookkeeping
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture_c  = 1'b0;
        seen_set_c = '0;
        seen_d     = seen_q;
        digits_d   = digits_q;
        err_d      = err_q;
        valid_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (one_hot_c) begin
                    state_d   = ST_TRACK;
                    cnt_d     = CNT_W'(1);
                    capture_c = RESTART_HIT;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_TRACK, ST_HELD: begin
                if (!one_hot_c) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (!same_c) begin
                    // New dwell or a glitch: start counting again
                    state_d   = ST_TRACK;
                    cnt_d     = CNT_W'(1);
                    capture_c = RESTART_HIT;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                    // HELD never recaptures, so a stable dwell yields one capture
                    if ((state_q == ST_TRACK) &&
                        (cnt_d >= CNT_W'(STABLE_CYCLES))) begin
                        capture_c = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (capture_c) begin
            state_d = ST_HELD;
            // The low anode selects which nibble and flag are written
            for (int unsigned k = 0; k < N_DIGITS; k++) begin
                if (low_c[k]) begin
                    digits_d[k*NIB_W +: NIB_W] = dec_nib_c;
                    err_d[k]                   = dec_err_c;
                end
            end
            // Frame completion takes priority over recording the new bit
            seen_set_c = seen_q | low_c;
            if (&seen_set_c) begin
                valid_d = 1'b1;
                seen_d  = '0;
            end else begin
                seen_d  = seen_set_c;
            end
        end
    end

    assign o_digits = digits_q;
    assign o_err    = err_q;
    assign o_valid  = valid_q;

endmodule

// File: tb/tb_sseg_reader.sv
// Bench for sseg_reader: directed scenarios followed by random dwells,
// checked through an expected-response queue against a run-length model.
module tb_sseg_reader;

    localparam int unsigned ND = 4;
    localparam int unsigned SC = 4;

    logic        i_clk;
    logic        i_rst_n;
    logic [6:0]  i_sseg;
    logic [3:0]  i_an;
    logic [15:0] o_digits;
    logic [3:0]  o_err;
    logic        o_valid;

    sseg_reader #(.N_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_sseg   (i_sseg),
        .i_an     (i_an),
        .o_digits (o_digits),
        .o_err    (o_err),
        .o_valid  (o_valid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int valid_seen = 0;
    int edge_n   = 0;

    typedef struct {
        int          tag;
        logic [15:0] d;
        logic [3:0]  e;
        logic        v;
    } exp_t;

    exp_t sb_q[$];

    // Model state
    logic [15:0] m_digits;
    logic [3:0]  m_err;
    logic [3:0]  m_seen;
    logic [3:0]  last_an;
    logic [6:0]  last_sg;
    int          run;
    bit          pend;
    logic [3:0]  pend_an;
    logic [6:0]  pend_sg;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic int low_idx(input logic [3:0] an);
        int zeros = 0;
        int idx = -1;
        for (int i = 0; i < 4; i++) begin
            if (an[i] == 1'b0) begin
                zeros++;
                idx = i;
            end
        end
        return (zeros == 1) ? idx : -1;
    endfunction

    task automatic decode(input logic [6:0] sg, output logic [3:0] nib, output logic er);
        er = 1'b0;
        case (sg)
            7'b1000000: nib = 4'h0;
            7'b1111001: nib = 4'h1;
            7'b0100100: nib = 4'h2;
            7'b0110000: nib = 4'h3;
            7'b0011001: nib = 4'h4;
            7'b0010010: nib = 4'h5;
            7'b0000010: nib = 4'h6;
            7'b1111000: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0010000: nib = 4'h9;
            7'b0001001: nib = 4'hF;
            default: begin nib = 4'h0; er = 1'b1; end
        endcase
    endtask

    // Model for one rising edge: a digit is captured one edge after the
    // S-th identical one-hot sample has been registered.
    task automatic model_edge();
        logic [15:0] nd;
        logic [3:0]  ne;
        logic [3:0]  nib;
        logic        er;
        logic        v;
        int          k;
        edge_n++;
        if (!i_rst_n) begin
            m_digits = '0; m_err = '0; m_seen = '0;
            last_an = '1; last_sg = '1; run = 0; pend = 1'b0;
            return;
        end
        if (pend) begin
            k = low_idx(pend_an);
            decode(pend_sg, nib, er);
            nd = m_digits;
            ne = m_err;
            nd[k*4 +: 4] = nib;
            ne[k] = er;
            m_seen[k] = 1'b1;
            v = (m_seen == 4'hF);
            if (v) m_seen = '0;
            if (v || nd != m_digits || ne != m_err)
                sb_q.push_back('{tag: edge_n, d: nd, e: ne, v: v});
            m_digits = nd;
            m_err = ne;
        end
        if (i_an == last_an && i_sseg == last_sg) begin
            if (run < 1000) run++;
        end else begin
            run = 1;
        end
        last_an = i_an;
        last_sg = i_sseg;
        pend    = (low_idx(i_an) >= 0) && (run == SC);
        pend_an = i_an;
        pend_sg = i_sseg;
    endtask

    // Monitor: any output change or strobe must match the queue head
    logic [15:0] prev_d = '0;
    logic [3:0]  prev_e = '0;
    always @(negedge i_clk) begin
        bit   ev;
        bit   exp_ev;
        exp_t it;
        if (!i_rst_n) begin
            prev_d = o_digits;
            prev_e = o_err;
        end else begin
            ev     = (o_digits != prev_d) || (o_err != prev_e) || (o_valid == 1'b1);
            exp_ev = (sb_q.size() > 0) && (sb_q[0].tag == edge_n);
            if (exp_ev) begin
                it = sb_q.pop_front();
                chk("capture", {43'd0, o_digits, o_err, o_valid}, {43'd0, it.d, it.e, it.v});
            end else if (ev) begin
                chk("spurious_out", {43'd0, o_digits, o_err, o_valid}, {43'd0, m_digits, m_err, 1'b0});
            end
            if (o_valid) valid_seen++;
            prev_d = o_digits;
            prev_e = o_err;
        end
    end

    // One clock of stimulus; called and returns in the low clock phase
    task automatic drive(input logic [3:0] an, input logic [6:0] sg, input int n);
        for (int i = 0; i < n; i++) begin
            i_an = an;
            i_sseg = sg;
            @(posedge i_clk);
            model_edge();
            @(negedge i_clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        #1 i_rst_n = 1'b0;
        #1;
        chk("rst_digits", 64'(o_digits), 64'd0);
        chk("rst_err",    64'(o_err),    64'd0);
        chk("rst_valid",  64'(o_valid),  64'd0);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk);
            model_edge();
            @(negedge i_clk);
            #1;
        end
        i_rst_n = 1'b1;
    endtask

    logic [6:0] pats [11];
    int v0;

    initial begin
        pats = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                 7'b0001001};
        i_rst_n = 1'b1;
        i_an = '1;
        i_sseg = '1;
        m_digits = '0; m_err = '0; m_seen = '0;
        last_an = '1; last_sg = '1; run = 0; pend = 1'b0;
        #1;
        do_reset(2);

        // Blank bus: nothing captured
        drive(4'b1111, 7'b1111111, 10);
        chk("idle_digits", 64'(o_digits), 64'd0);
        chk("idle_valid_cnt", 64'(valid_seen), 64'd0);

        // Single capture: not yet after 4 edges, present on the next
        drive(4'b1110, 7'b0110000, 4);
        chk("single_latency", 64'(o_digits[3:0]), 64'h0);
        drive(4'b1111, 7'b1111111, 1);
        chk("single_nib", 64'(o_digits[3:0]), 64'h3);
        chk("single_err", 64'(o_err[0]), 64'd0);

        // Glitch rejection on digit 1
        drive(4'b1101, 7'b0100100, 3);
        drive(4'b1101, 7'b1111001, 4);
        drive(4'b1111, 7'b1111111, 2);
        chk("glitch_nib", 64'(o_digits[7:4]), 64'h1);

        // Full frame after a mid-run reset
        do_reset(2);
        v0 = valid_seen;
        drive(4'b1110, 7'b1111001, 6);
        drive(4'b1101, 7'b0100100, 6);
        drive(4'b1011, 7'b0110000, 6);
        drive(4'b0111, 7'b0011001, 6);
        drive(4'b1111, 7'b1111111, 2);
        chk("frame_digits", 64'(o_digits), 64'h4321);
        chk("frame_valid_cnt", 64'(valid_seen - v0), 64'd1);

        // "H" and an unrecognised pattern on digit 2
        drive(4'b1011, 7'b0001001, 6);
        chk("h_nib", 64'(o_digits[11:8]), 64'hF);
        chk("h_err", 64'(o_err[2]), 64'd0);
        drive(4'b1011, 7'b1111111, 6);
        chk("bad_nib", 64'(o_digits[11:8]), 64'h0);
        chk("bad_err", 64'(o_err), 64'b0100);

        // Two anodes low: ignored
        drive(4'b1100, 7'b0010010, 10);
        chk("illegal_an", 64'(o_digits), 64'h4021);

        // Partial frame discarded by reset
        v0 = valid_seen;
        drive(4'b1110, 7'b0010010, 6);
        drive(4'b1101, 7'b0000010, 6);
        do_reset(2);
        drive(4'b1011, 7'b1111000, 6);
        drive(4'b0111, 7'b0000000, 6);
        drive(4'b1111, 7'b1111111, 2);
        chk("partial_digits", 64'(o_digits), 64'h8700);
        chk("partial_no_valid", 64'(valid_seen - v0), 64'd0);

        // Random dwells
        for (int n = 0; n < 400; n++) begin
            logic [3:0] an;
            logic [6:0] sg;
            if ($urandom_range(0, 99) < 85) an = ~(4'b0001 << $urandom_range(0, 3));
            else an = 4'($urandom);
            if ($urandom_range(0, 99) < 75) sg = pats[$urandom_range(0, 10)];
            else sg = 7'($urandom);
            if ($urandom_range(0, 199) == 0) do_reset(1);
            drive(an, sg, $urandom_range(1, 8));
            if (n % 50 == 49) begin
                chk("rand_digits", 64'(o_digits), 64'(m_digits));
                chk("rand_err", 64'(o_err), 64'(m_err));
            end
        end
        drive(4'b1111, 7'b1111111, 3);
        chk("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
